cnn_stream_pipe: RTL and testbench

CNN_STREAM_PIPE -- requirements
Module: cnn_stream_pipe

---
 rtl/cnn_stream_pipe_if.sv | 36 +++
 rtl/cnn_stream_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_cnn_stream_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_stream_pipe_if.sv
// Stream, configuration and status bundle for cnn_stream_pipe.
// The DUT binds to the slave modport and the pixel source/sink binds to the master modport.
interface cnn_stream_pipe_if #(
  parameter int DATA_W = 8
);
  // Both streams are valid/ready. A beat transfers on a rising clk edge where valid
  // and ready are both high. A source holds valid and its data stable until that edge.
  // in_ready depends combinationally on out_valid/out_ready, so one output stall
  // freezes the input side in the same cycle.
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] pixel_in;

  logic                     cfg_we;
  logic [3:0]               cfg_addr;
  logic signed [DATA_W-1:0] cfg_data;
  logic                     cfg_err;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  logic                     busy;
  logic [1:0]               dbg_state;

  modport master (
    output in_valid, pixel_in, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, cfg_err, out_valid, out_data, out_last, busy, dbg_state
  );

  modport slave (
    input  in_valid, pixel_in, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, cfg_err, out_valid, out_data, out_last, busy, dbg_state
  );
endinterface

// File: rtl/cnn_stream_pipe.sv
// Streaming 3x3 conv + batch-norm + leaky-ReLU over raster-order frames.
// Define CNN_STREAM_SAT_EN to saturate every DATA_W narrowing instead of wrapping it.
module cnn_stream_pipe #(
  parameter int DATA_W   = 8,
  parameter int FRAC     = 4,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int ACC_W    = 20,
  parameter int ALPHA_SH = 2
) (
  input logic              clk,
  input logic              rst,
  cnn_stream_pipe_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef logic signed [DATA_W-1:0]   pix_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic signed [2*DATA_W-1:0] prod_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam pix_t           W_ONE   = pix_t'(1 <<< FRAC);
  localparam logic [CW-1:0]  COL_END = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_END = RW'(IMG_H - 1);
`ifdef CNN_STREAM_SAT_EN
  localparam acc_t SAT_MAX = acc_t'((1 <<< (DATA_W - 1)) - 1);
  localparam acc_t SAT_MIN = -SAT_MAX - acc_t'(1);
`endif

  function automatic acc_t ext_pix(input pix_t v);
    return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic acc_t ext_prod(input prod_t v);
    return {{(ACC_W - 2*DATA_W){v[2*DATA_W-1]}}, v};
  endfunction

  function automatic pix_t narrow(input acc_t v);
`ifdef CNN_STREAM_SAT_EN
    if (v > SAT_MAX) return pix_t'(SAT_MAX);
    else if (v < SAT_MIN) return pix_t'(SAT_MIN);
    else return pix_t'(v);
`else
    return pix_t'(v);
`endif
  endfunction

  state_t        state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          stall;
  logic          accept;
  logic          col_end;
  logic          row_end;
  logic          busy;

  pix_t lb0 [IMG_W];
  pix_t lb1 [IMG_W];
  pix_t win [3][3];
  logic win_v, win_last;

  pix_t wt [9];
  pix_t bias, gamma, beta;

  acc_t mac_sum;
  acc_t conv_full;
  pix_t conv_q;
  logic mac_v, mac_last;

  acc_t bn_full;
  pix_t bn_q;
  logic bn_v, bn_last;
  pix_t act;

  // A stalled output freezes every stage at once, so no stage needs its own skid.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept       = bus.in_valid & ~stall;
  assign col_end      = (col == COL_END);
  assign row_end      = (row == ROW_END);

  assign busy          = (state != S_IDLE);
  assign bus.busy      = busy;
  assign bus.dbg_state = state;

  // ---------------- frame position ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // ---------------- frame FSM ----------------
  // DRAIN covers the tail between the last pixel and the consumed out_last; a new
  // frame's first pixel during DRAIN goes straight back to FRAME so busy never drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_FRAME;
      S_FRAME: if (accept && row_end && col_end) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (accept) state_nx = S_FRAME;
        else if (bus.out_valid && bus.out_ready && bus.out_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- line buffers and window ----------------
  // Column col of lb1/lb0 holds rows row-2/row-1; win[0] is the oldest row.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.pixel_in;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[col];
      win[1][2] <= lb0[col];
      win[2][2] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_v    <= 1'b0;
      win_last <= 1'b0;
    end else if (!stall) begin
      win_v    <= accept && (row >= RW'(2)) && (col >= CW'(2));
      win_last <= row_end && col_end;
    end
  end

  // ---------------- configuration ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 9; k++) wt[k] <= (k == 4) ? W_ONE : '0;
      bias        <= '0;
      gamma       <= W_ONE;
      beta        <= '0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.cfg_err <= bus.cfg_we & busy;
      if (bus.cfg_we && !busy) begin
        case (bus.cfg_addr)
          4'd9:    bias  <= bus.cfg_data;
          4'd10:   gamma <= bus.cfg_data;
          4'd11:   beta  <= bus.cfg_data;
          default: if (bus.cfg_addr < 4'd9) wt[bus.cfg_addr] <= bus.cfg_data;
        endcase
      end
    end
  end

  // ---------------- arithmetic ----------------
  always_comb begin
    mac_sum = ext_pix(bias) <<< FRAC;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        mac_sum = mac_sum + ext_prod(prod_t'(win[i][j]) * prod_t'(wt[i*3+j]));
      end
    end
    conv_full = mac_sum >>> FRAC;
  end

  always_comb begin
    bn_full = (ext_prod(prod_t'(conv_q) * prod_t'(gamma)) >>> FRAC) + ext_pix(beta);
  end

  always_comb begin
    act = bn_q[DATA_W-1] ? (bn_q >>> ALPHA_SH) : bn_q;
  end

  // ---------------- MAC -> BN -> activation registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_v         <= 1'b0;
      mac_last      <= 1'b0;
      conv_q        <= '0;
      bn_v          <= 1'b0;
      bn_last       <= 1'b0;
      bn_q          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else if (!stall) begin
      mac_v         <= win_v;
      mac_last      <= win_v & win_last;
      conv_q        <= narrow(conv_full);
      bn_v          <= mac_v;
      bn_last       <= mac_v & mac_last;
      bn_q          <= narrow(bn_full);
      bus.out_valid <= bn_v;
      bus.out_last  <= bn_v & bn_last;
      bus.out_data  <= act;
    end
  end

endmodule

// File: tb/tb_cnn_stream_pipe.sv
// Directed bench for cnn_stream_pipe: reference model feeds an expected queue that
// the output monitor drains; covers identity, backpressure, lockout, leaky, resets, overflow.
module tb_cnn_stream_pipe;

  localparam int DATA_W   = 8;
  localparam int FRAC     = 4;
  localparam int IMG_W    = 8;
  localparam int IMG_H    = 8;
  localparam int ACC_W    = 20;
  localparam int ALPHA_SH = 2;
  localparam int NWIN     = (IMG_W - 2) * (IMG_H - 2);
`ifdef CNN_STREAM_SAT_EN
  localparam int OVF_EXP = 127;
`else
  localparam int OVF_EXP = 16;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  cnn_stream_pipe_if #(.DATA_W(DATA_W)) bus ();

  cnn_stream_pipe #(
    .DATA_W(DATA_W), .FRAC(FRAC), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .ACC_W(ACC_W), .ALPHA_SH(ALPHA_SH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0]          exp_q[$];
  int                       n_checks = 0;
  int                       n_pass   = 0;
  int                       out_cnt  = 0;
  logic signed [DATA_W-1:0] first_out, last_out;
  int                       first_edge = 0;
  int                       win_edge   = 0;
  int                       px_idx     = 0;
  bit                       seen_valid = 1'b0;
  bit                       mon_en     = 1'b0;
  logic [DATA_W:0]          mon_e;
  logic signed [DATA_W-1:0] mon_ed;

  int m_w [9];
  int m_bias, m_gamma, m_beta;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int narrow_m(input int v);
`ifdef CNN_STREAM_SAT_EN
    if (v > (2**(DATA_W-1)) - 1) return (2**(DATA_W-1)) - 1;
    if (v < -(2**(DATA_W-1)))    return -(2**(DATA_W-1));
    return v;
`else
    logic signed [DATA_W-1:0] t;
    t = v[DATA_W-1:0];
    return int'(t);
`endif
  endfunction

  function automatic int pix_val(input int mode, input int r, input int c);
    case (mode)
      0:       return r * IMG_W + c;
      1:       return -32;
      default: return 100;
    endcase
  endfunction

  task automatic set_identity();
    for (int k = 0; k < 9; k++) m_w[k] = (k == 4) ? (1 << FRAC) : 0;
    m_bias  = 0;
    m_gamma = 1 << FRAC;
    m_beta  = 0;
  endtask

  task automatic push_frame(input int mode);
    int acc, conv, bn, act;
    logic [DATA_W:0] e;
    for (int r = 2; r < IMG_H; r++) begin
      for (int c = 2; c < IMG_W; c++) begin
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += pix_val(mode, r - 2 + i, c - 2 + j) * m_w[i*3+j];
        conv = narrow_m((acc + m_bias * (1 << FRAC)) >>> FRAC);
        bn   = narrow_m(((conv * m_gamma) >>> FRAC) + m_beta);
        act  = (bn < 0) ? (bn >>> ALPHA_SH) : bn;
        e    = {(r == IMG_H - 1) && (c == IMG_W - 1), act[DATA_W-1:0]};
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (mon_en && bus.out_valid && !seen_valid) begin
      seen_valid = 1'b1;
      first_edge = cyc;
    end
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", exp_q.size(), 1);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ed = mon_e[DATA_W-1:0];
        check("out_data", bus.out_data, mon_ed);
        check("out_last", bus.out_last, mon_e[DATA_W]);
      end
      if (out_cnt == 0) first_out = bus.out_data;
      last_out = bus.out_data;
      out_cnt++;
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic drive_pixels(input int mode, input int count);
    int r, c, guard;
    for (int k = 0; k < count; k++) begin
      r = (k / IMG_W) % IMG_H;
      c = k % IMG_W;
      bus.in_valid = 1'b1;
      bus.pixel_in = DATA_W'(pix_val(mode, r, c));
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 100) check("in_ready_timeout", bus.in_ready, 1);
      if (k == 2 * IMG_W + 2) win_edge = cyc + 1;
      @(posedge clk);
      #1;
      px_idx = k + 1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_frame(input int mode);
    drive_pixels(mode, IMG_W * IMG_H);
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(addr);
    bus.cfg_data = DATA_W'(data);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic clear_stats();
    out_cnt    = 0;
    seen_valid = 1'b0;
    px_idx     = 0;
    first_out  = '0;
    last_out   = '0;
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.busy) && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_busy_low"}, bus.busy, 0);
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_cfg_err"}, bus.cfg_err, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_state"}, bus.dbg_state, 0);
  endtask

  task automatic stall_seq();
    int guard;
    logic [DATA_W:0] f;
    logic signed [DATA_W-1:0] fd;
    guard = 0;
    while (out_cnt < 8 && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      f  = (exp_q.size() != 0) ? exp_q[0] : '0;
      fd = f[DATA_W-1:0];
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_out_valid_held", bus.out_valid, 1);
      check("bp_out_data_held", bus.out_data, fd);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  task automatic lockout_seq();
    int guard;
    guard = 0;
    while (px_idx < 30 && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd4;
    bus.cfg_data = '0;
    @(negedge clk);
    check("lock_busy", bus.busy, 1);
    check("lock_err_before", bus.cfg_err, 0);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    @(negedge clk);
    check("lock_err_pulse", bus.cfg_err, 1);
    @(negedge clk);
    check("lock_err_clear", bus.cfg_err, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.pixel_in  = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.out_ready = 1'b1;
    set_identity();

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    reset_checks("reset");
    realign();

    // identity config, ramp frame: first 9, last 54, 3-cycle latency
    mon_en = 1'b1;
    clear_stats();
    push_frame(0);
    drive_frame(0);
    wait_drain("ident");
    check("ident_count", out_cnt, NWIN);
    check("ident_first", first_out, 9);
    check("ident_last", last_out, 54);
    check("ident_latency", first_edge - win_edge, 3);
    realign();

    // output backpressure mid-frame
    clear_stats();
    push_frame(0);
    fork
      drive_frame(0);
      stall_seq();
    join
    wait_drain("bp");
    check("bp_count", out_cnt, NWIN);
    realign();

    // config write while busy is dropped
    clear_stats();
    push_frame(0);
    fork
      drive_frame(0);
      lockout_seq();
    join
    wait_drain("lock");
    check("lock_count", out_cnt, NWIN);
    realign();

    // reserved address is silently ignored; then leaky slope on negative frame
    cfg_write(12, 55);
    @(negedge clk);
    check("cfg_reserved_err", bus.cfg_err, 0);
    realign();
    clear_stats();
    push_frame(1);
    drive_frame(1);
    wait_drain("leaky");
    check("leaky_count", out_cnt, NWIN);
    check("leaky_last", last_out, -8);
    realign();

    // reset mid-frame, then two back-to-back ramp frames
    mon_en = 1'b0;
    drive_pixels(0, 20);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    set_identity();
    reset_checks("midrst");
    realign();
    mon_en = 1'b1;
    clear_stats();
    push_frame(0);
    push_frame(0);
    drive_frame(0);
    drive_frame(0);
    wait_drain("b2b");
    check("b2b_count", out_cnt, 2 * NWIN);
    check("b2b_first", first_out, 9);
    check("b2b_last", last_out, 54);
    realign();

    // overflow: all weights 64, flat frame of 100
    for (int a = 0; a < 9; a++) begin
      cfg_write(a, 64);
      m_w[a] = 64;
    end
    @(negedge clk);
    check("ovf_cfg_err", bus.cfg_err, 0);
    realign();
    clear_stats();
    push_frame(2);
    drive_frame(2);
    wait_drain("ovf");
    check("ovf_count", out_cnt, NWIN);
    check("ovf_last", last_out, OVF_EXP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
